// File: rtl/mask_drain_if.sv
// Handshake bundle for mask_drain: request vector in, one-hot select beats out.
// The slave modport is the drain itself; master is the upstream/consumer side.
interface mask_drain_if #(
  parameter int W = 32
);
  localparam int IW = $clog2(W);

  logic          i_mask_vld;
  logic [W-1:0]  i_mask;
  logic          o_mask_rdy;
  logic          o_sel_vld;
  logic [W-1:0]  o_sel;
  logic [IW-1:0] o_sel_idx;
  logic          o_sel_last;
  logic          i_sel_rdy;
  logic          o_busy;

  modport master (
    output i_mask_vld, i_mask, i_sel_rdy,
    input  o_mask_rdy, o_sel_vld, o_sel, o_sel_idx, o_sel_last, o_busy
  );

  modport slave (
    input  i_mask_vld, i_mask, i_sel_rdy,
    output o_mask_rdy, o_sel_vld, o_sel, o_sel_idx, o_sel_last, o_busy
  );
endinterface

// File: rtl/mask_drain.sv
// Serialises a multi-hot request vector into one-hot select beats in priority order.
// Optional MASK_DRAIN_BYPASS_EN lets the next vector load as the final beat retires.
module mask_drain #(
  parameter int W           = 32,
  parameter bit TOWARDS_LSB = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mask_drain_if.slave bus
);
  localparam int IW = $clog2(W);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic [W-1:0]  pending;

  logic [W-1:0]  sel;
  logic [IW-1:0] idx;
  logic          last;
  logic          active;
  logic          mask_rdy;
  logic          mask_fire;
  logic          sel_fire;
  logic          mask_nonzero;

  // Later loop iterations overwrite earlier ones, so the loop direction picks the winner.
  always_comb begin
    sel = '0;
    idx = '0;
    if (TOWARDS_LSB) begin
      for (int i = 0; i < W; i++) begin
        if (pending[i]) begin
          sel    = '0;
          sel[i] = 1'b1;
          idx    = i[IW-1:0];
        end
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (pending[i]) begin
          sel    = '0;
          sel[i] = 1'b1;
          idx    = i[IW-1:0];
        end
      end
    end
  end

  assign last         = (pending & ~sel) == '0;
  assign active       = (state == BUSY) && !rst;
  assign mask_nonzero = |bus.i_mask;

`ifdef MASK_DRAIN_BYPASS_EN
  assign mask_rdy = !rst && ((state == IDLE) || ((state == BUSY) && bus.i_sel_rdy && last));
`else
  assign mask_rdy = !rst && (state == IDLE);
`endif

  assign mask_fire = bus.i_mask_vld && mask_rdy;
  assign sel_fire  = active && bus.i_sel_rdy;

  assign bus.o_mask_rdy = mask_rdy;
  assign bus.o_sel_vld  = active;
  assign bus.o_busy     = active;
  assign bus.o_sel      = active ? sel : '0;
  assign bus.o_sel_idx  = active ? idx : '0;
  assign bus.o_sel_last = active && last;

  // Retiring the final beat either empties the block or, with bypass, reloads it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mask_fire && mask_nonzero) begin
            pending <= bus.i_mask;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (sel_fire) begin
            if (last) begin
`ifdef MASK_DRAIN_BYPASS_EN
              if (mask_fire && mask_nonzero) begin
                pending <= bus.i_mask;
              end else begin
                pending <= '0;
                state   <= IDLE;
              end
`else
              pending <= '0;
              state   <= IDLE;
`endif
            end else begin
              pending <= pending & ~sel;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mask_drain.sv
// Self-checking bench for mask_drain: two W=8 instances (MSB-first and LSB-first)
// driven with identical stimulus; directed scenarios then a randomized model comparison.
module tb_mask_drain;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

`ifdef MASK_DRAIN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  mask_drain_if #(.W(8)) bus_hi ();
  mask_drain_if #(.W(8)) bus_lo ();

  mask_drain #(.W(8), .TOWARDS_LSB(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));
  mask_drain #(.W(8), .TOWARDS_LSB(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));

  // Observed word: {vld, mask_rdy, busy, last, idx[2:0], sel[7:0]}
  logic [14:0] obs_hi;
  logic [14:0] obs_lo;
  assign obs_hi = {bus_hi.o_sel_vld, bus_hi.o_mask_rdy, bus_hi.o_busy, bus_hi.o_sel_last,
                   bus_hi.o_sel_idx, bus_hi.o_sel};
  assign obs_lo = {bus_lo.o_sel_vld, bus_lo.o_mask_rdy, bus_lo.o_busy, bus_lo.o_sel_last,
                   bus_lo.o_sel_idx, bus_lo.o_sel};

  function automatic logic [14:0] pk(input logic v, input logic r, input logic b,
                                     input logic l, input logic [2:0] i, input logic [7:0] s);
    return {v, r, b, l, i, s};
  endfunction

  localparam logic [14:0] IDLE_W = 15'h2000;
  localparam logic [14:0] ZERO_W = 15'h0000;

  // Drive both instances on the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic vld, input logic [7:0] mask,
                               input logic sel_rdy, input logic r);
    @(negedge clk);
    rst               = r;
    bus_hi.i_mask_vld = vld;
    bus_hi.i_mask     = mask;
    bus_hi.i_sel_rdy  = sel_rdy;
    bus_lo.i_mask_vld = vld;
    bus_lo.i_mask     = mask;
    bus_lo.i_sel_rdy  = sel_rdy;
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (obs_hi !== ZERO_W) begin failures++; $display("[TB] FAIL reset_hold hi got=%h exp=%h", obs_hi, ZERO_W); end
    checks++; if (obs_lo !== ZERO_W) begin failures++; $display("[TB] FAIL reset_hold lo got=%h exp=%h", obs_lo, ZERO_W); end
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++; if (obs_hi !== IDLE_W) begin failures++; $display("[TB] FAIL reset_idle hi got=%h exp=%h", obs_hi, IDLE_W); end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (obs_hi !== pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h80)) begin failures++; $display("[TB] FAIL reset_busy hi got=%h", obs_hi); end
    checks++; if (obs_lo !== pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01)) begin failures++; $display("[TB] FAIL reset_busy lo got=%h", obs_lo); end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checks++; if (obs_hi !== ZERO_W) begin failures++; $display("[TB] FAIL reset_mid hi cyc%0d got=%h exp=%h", k, obs_hi, ZERO_W); end
      checks++; if (obs_lo !== ZERO_W) begin failures++; $display("[TB] FAIL reset_mid lo cyc%0d got=%h exp=%h", k, obs_lo, ZERO_W); end
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (obs_hi !== IDLE_W) begin failures++; $display("[TB] FAIL reset_after hi cyc%0d got=%h exp=%h", k, obs_hi, IDLE_W); end
      checks++; if (obs_lo !== IDLE_W) begin failures++; $display("[TB] FAIL reset_after lo cyc%0d got=%h exp=%h", k, obs_lo, IDLE_W); end
    end
  endtask

  task automatic test_drain();
    logic [7:0] sh[3] = '{8'h80, 8'h20, 8'h04};
    logic [2:0] ih[3] = '{3'd7, 3'd5, 3'd2};
    logic [7:0] sl[3] = '{8'h04, 8'h20, 8'h80};
    logic [2:0] il[3] = '{3'd2, 3'd5, 3'd7};
    logic [14:0] eh, el;
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
    checks++; if (obs_hi !== IDLE_W) begin failures++; $display("[TB] FAIL drain_accept hi got=%h exp=%h", obs_hi, IDLE_W); end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      eh = pk(1'b1, BYP && (k == 2), 1'b1, k == 2, ih[k], sh[k]);
      el = pk(1'b1, BYP && (k == 2), 1'b1, k == 2, il[k], sl[k]);
      checks++; if (obs_hi !== eh) begin failures++; $display("[TB] FAIL drain_beat hi cyc%0d got=%h exp=%h", k, obs_hi, eh); end
      checks++; if (obs_lo !== el) begin failures++; $display("[TB] FAIL drain_beat lo cyc%0d got=%h exp=%h", k, obs_lo, el); end
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (obs_hi !== IDLE_W) begin failures++; $display("[TB] FAIL drain_end hi got=%h exp=%h", obs_hi, IDLE_W); end
    checks++; if (obs_lo !== IDLE_W) begin failures++; $display("[TB] FAIL drain_end lo got=%h exp=%h", obs_lo, IDLE_W); end
  endtask

  task automatic test_backpressure();
    logic [14:0] e;
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      e = pk(1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80);
      checks++; if (obs_hi !== e) begin failures++; $display("[TB] FAIL bp_hold hi cyc%0d got=%h exp=%h", k, obs_hi, e); end
      checks++; if (obs_lo !== e) begin failures++; $display("[TB] FAIL bp_hold lo cyc%0d got=%h exp=%h", k, obs_lo, e); end
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    e = pk(1'b1, BYP, 1'b1, 1'b1, 3'd7, 8'h80);
    checks++; if (obs_hi !== e) begin failures++; $display("[TB] FAIL bp_release hi got=%h exp=%h", obs_hi, e); end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (obs_hi !== IDLE_W) begin failures++; $display("[TB] FAIL bp_no_accept hi cyc%0d got=%h exp=%h", k, obs_hi, IDLE_W); end
      checks++; if (obs_lo !== IDLE_W) begin failures++; $display("[TB] FAIL bp_no_accept lo cyc%0d got=%h exp=%h", k, obs_lo, IDLE_W); end
    end
  endtask

  task automatic test_zero();
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    checks++; if (obs_hi !== IDLE_W) begin failures++; $display("[TB] FAIL zero_accept hi got=%h exp=%h", obs_hi, IDLE_W); end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (obs_hi !== IDLE_W) begin failures++; $display("[TB] FAIL zero_idle hi cyc%0d got=%h exp=%h", k, obs_hi, IDLE_W); end
      checks++; if (obs_lo !== IDLE_W) begin failures++; $display("[TB] FAIL zero_idle lo cyc%0d got=%h exp=%h", k, obs_lo, IDLE_W); end
    end
  endtask

  task automatic test_towards_msb();
    logic [14:0] e;
    applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    e = pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01);
    checks++; if (obs_lo !== e) begin failures++; $display("[TB] FAIL msb_first lo got=%h exp=%h", obs_lo, e); end
    e = pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h80);
    checks++; if (obs_hi !== e) begin failures++; $display("[TB] FAIL msb_first hi got=%h exp=%h", obs_hi, e); end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    e = pk(1'b1, BYP, 1'b1, 1'b1, 3'd7, 8'h80);
    checks++; if (obs_lo !== e) begin failures++; $display("[TB] FAIL msb_second lo got=%h exp=%h", obs_lo, e); end
    e = pk(1'b1, BYP, 1'b1, 1'b1, 3'd0, 8'h01);
    checks++; if (obs_hi !== e) begin failures++; $display("[TB] FAIL msb_second hi got=%h exp=%h", obs_hi, e); end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (obs_lo !== IDLE_W) begin failures++; $display("[TB] FAIL msb_end lo got=%h exp=%h", obs_lo, IDLE_W); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  st[$];
    logic [14:0] eh[$];
    logic [14:0] el[$];
    st = '{{1'b1, 8'h03}, {1'b1, 8'h10}, {1'b1, 8'h10}};
    eh = '{IDLE_W, pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h02), pk(1'b1, BYP, 1'b1, 1'b1, 3'd0, 8'h01)};
    el = '{IDLE_W, pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01), pk(1'b1, BYP, 1'b1, 1'b1, 3'd1, 8'h02)};
`ifdef MASK_DRAIN_BYPASS_EN
    st.push_back({1'b0, 8'h00});
    eh.push_back(pk(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10));
    el.push_back(pk(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10));
`else
    st.push_back({1'b1, 8'h10});
    eh.push_back(IDLE_W);
    el.push_back(IDLE_W);
    st.push_back({1'b0, 8'h00});
    eh.push_back(pk(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10));
    el.push_back(pk(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10));
`endif
    st.push_back({1'b0, 8'h00});
    eh.push_back(IDLE_W);
    el.push_back(IDLE_W);
    for (int k = 0; k < st.size(); k++) begin
      applyStimulus(st[k][8], st[k][7:0], 1'b1, 1'b0);
      checks++; if (obs_hi !== eh[k]) begin failures++; $display("[TB] FAIL b2b hi cyc%0d got=%h exp=%h", k, obs_hi, eh[k]); end
      checks++; if (obs_lo !== el[k]) begin failures++; $display("[TB] FAIL b2b lo cyc%0d got=%h exp=%h", k, obs_lo, el[k]); end
    end
  endtask

  // Reference: each accepted vector becomes a queue of bit positions in drain order.
  task automatic test_random();
    int          qh[$];
    int          ql[$];
    logic        vld = 1'b0;
    logic [7:0]  mask = 8'h00;
    logic        srdy, r, ev, er, acc;
    logic [14:0] eh, el;
    int          n;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!vld) begin
        vld = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0:       mask = 8'h00;
          1:       mask = 8'hFF;
          2:       mask = 8'(1 << $urandom_range(0, 7));
          default: mask = 8'($urandom);
        endcase
      end
      srdy = ($urandom_range(0, 3) != 0);
      r    = ($urandom_range(0, 199) == 0);
      applyStimulus(vld, mask, srdy, r);
      n  = qh.size();
      ev = (n > 0);
      er = (n == 0) || (BYP && n == 1 && srdy);
      if (r) begin
        eh = ZERO_W;
        el = ZERO_W;
      end else begin
        eh = ev ? pk(1'b1, er, 1'b1, n == 1, 3'(qh[0]), 8'(1 << qh[0])) : IDLE_W;
        el = ev ? pk(1'b1, er, 1'b1, n == 1, 3'(ql[0]), 8'(1 << ql[0])) : IDLE_W;
      end
      checks++; if (obs_hi !== eh) begin failures++; $display("[TB] FAIL rand hi cyc%0d got=%h exp=%h", cyc, obs_hi, eh); end
      checks++; if (obs_lo !== el) begin failures++; $display("[TB] FAIL rand lo cyc%0d got=%h exp=%h", cyc, obs_lo, el); end
      if (r) begin
        qh.delete();
        ql.delete();
        vld = 1'b0;
      end else begin
        acc = vld && er;
        if (ev && srdy) begin
          void'(qh.pop_front());
          void'(ql.pop_front());
        end
        if (acc) begin
          for (int i = 7; i >= 0; i--) if (mask[i]) qh.push_back(i);
          for (int i = 0; i < 8; i++) if (mask[i]) ql.push_back(i);
          vld = 1'b0;
        end
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    rst               = 1'b1;
    bus_hi.i_mask_vld = 1'b0;
    bus_hi.i_mask     = 8'h00;
    bus_hi.i_sel_rdy  = 1'b0;
    bus_lo.i_mask_vld = 1'b0;
    bus_lo.i_mask     = 8'h00;
    bus_lo.i_sel_rdy  = 1'b0;
    test_reset();
    test_drain();
    test_backpressure();
    test_zero();
    test_towards_msb();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end
endmodule
